// File: rtl/pulsed_decoder_pkg.sv
// Shared types and decode helper for the registered/pulsed binary-to-one-hot decoder.
package pulsed_decoder_pkg;

  // Widest supported code and the output vector it can address
  localparam int unsigned MAX_ENC_WIDTH = 8;
  localparam int unsigned MAX_OUTPUTS   = 256;

  // ST_ACTIVE is HOLD in level mode and PULSE in pulse mode
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // One-hot decode with code 0 on the MSB of an n-bit vector; all-zero for code >= n
  function automatic logic [MAX_OUTPUTS-1:0] onehot_msb_first(
    input logic [MAX_ENC_WIDTH-1:0] code,
    input int unsigned              n
  );
    logic [MAX_OUTPUTS-1:0]   vec;
    logic [MAX_ENC_WIDTH-1:0] idx;
    vec = '0;
    idx = '0;
    if (32'(code) < n) begin
      idx      = MAX_ENC_WIDTH'(n - 32'd1 - 32'(code));
      vec[idx] = 1'b1;
    end
    return vec;
  endfunction

endpackage

// File: rtl/pulsed_decoder_n.sv
// Registered parametrised decoder: binary code -> one of NUM_OUTPUTS one-hot lines.
// A valid/ready handshake captures each code. The selected line is held (level
// mode, PULSE_CYCLES=0) or asserted for PULSE_CYCLES clocks (pulse mode).
// Out-of-range codes clear the outputs and set a sticky error flag.
//
// Ports:
//   Clock_In           rising-edge clock
//   Reset_In           asynchronous active-high reset
//   Clear_In           synchronous clear of outputs, FSM and error flag
//   Encoded_Value_In   binary code to decode
//   Encoded_Valid_In   code present this cycle
//   Encoded_Ready_Out  block can accept a code this cycle
//   Decoded_Value_Out  one-hot (or all-zero) decoded lines, code 0 -> MSB
//   Decoded_Valid_Out  Decoded_Value_Out currently drives a selection
//   Error_Out          sticky: an out-of-range code was accepted
module pulsed_decoder_n
  import pulsed_decoder_pkg::*;
#(
  parameter int unsigned ENC_WIDTH    = 2,
  parameter int unsigned NUM_OUTPUTS  = 4,
  parameter int unsigned PULSE_CYCLES = 0
) (
  input  logic                   Clock_In,
  input  logic                   Reset_In,
  input  logic                   Clear_In,
  input  logic [ENC_WIDTH-1:0]   Encoded_Value_In,
  input  logic                   Encoded_Valid_In,
  output logic                   Encoded_Ready_Out,
  output logic [NUM_OUTPUTS-1:0] Decoded_Value_Out,
  output logic                   Decoded_Valid_Out,
  output logic                   Error_Out
);

  localparam int unsigned CNT_W      = (PULSE_CYCLES < 1) ? 1 : $clog2(PULSE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (PULSE_CYCLES == 0) ? '0 : CNT_W'(PULSE_CYCLES - 1);
  localparam bit          PULSE_MODE = (PULSE_CYCLES != 0);

  // Elaboration-time parameter checks
  if (ENC_WIDTH < 1 || ENC_WIDTH > MAX_ENC_WIDTH) begin : g_bad_enc_width
    $error("pulsed_decoder_n: ENC_WIDTH must be 1..8");
  end
  if (NUM_OUTPUTS < 2 || NUM_OUTPUTS > (32'd1 << ENC_WIDTH)) begin : g_bad_num_outputs
    $error("pulsed_decoder_n: NUM_OUTPUTS must be 2..2**ENC_WIDTH");
  end

  state_e                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   ready_q;
  logic [NUM_OUTPUTS-1:0] decode_c;
  logic                   accept_c;

  // Combinational decode of the presented code; all-zero means out of range
  assign decode_c = NUM_OUTPUTS'(onehot_msb_first(MAX_ENC_WIDTH'(Encoded_Value_In), NUM_OUTPUTS));

  // ready_q keeps ready low until the first edge after reset; clear masks it in its own cycle
  assign Encoded_Ready_Out = ready_q & ~Clear_In & (~PULSE_MODE | (state == ST_IDLE));
  assign accept_c          = Encoded_Valid_In & Encoded_Ready_Out;

  // FSM, pulse counter and registered outputs
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      ready_q           <= 1'b0;
      Decoded_Value_Out <= '0;
      Decoded_Valid_Out <= 1'b0;
      Error_Out         <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (Clear_In) begin
        state             <= ST_IDLE;
        cnt               <= '0;
        Decoded_Value_Out <= '0;
        Decoded_Valid_Out <= 1'b0;
        Error_Out         <= 1'b0;
      end else if (accept_c) begin
        if (|decode_c) begin
          state             <= ST_ACTIVE;
          cnt               <= CNT_LOAD;
          Decoded_Value_Out <= decode_c;
          Decoded_Valid_Out <= 1'b1;
        end else begin
          state             <= ST_IDLE;
          cnt               <= '0;
          Decoded_Value_Out <= '0;
          Decoded_Valid_Out <= 1'b0;
          Error_Out         <= 1'b1;
        end
      end else if (PULSE_MODE && state == ST_ACTIVE) begin
        // Counter is loaded with PULSE_CYCLES-1 so the line is high exactly PULSE_CYCLES cycles
        if (cnt == '0) begin
          state             <= ST_IDLE;
          Decoded_Value_Out <= '0;
          Decoded_Valid_Out <= 1'b0;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pulsed_decoder_n.sv
// Bench for pulsed_decoder_n: three configurations (level, 3-cycle pulse, 1-cycle
// pulse) driven by directed and random stimulus against a cycle-level model that
// tracks the selected line, remaining high cycles and the error flag.
module tb_pulsed_decoder_n;

  logic       clk;
  logic       rst;
  logic [2:0] clr;
  logic [2:0] vld;
  logic [2:0] code [3];
  logic [1:0] code_p1;

  logic [2:0] rdy;
  logic [2:0] dv;
  logic [2:0] err;
  logic [5:0] val0;
  logic [4:0] val1;
  logic [3:0] val2;

  int n_checks = 0;
  int n_fail   = 0;

  // Model configuration and state per instance
  int np [3] = '{6, 5, 4};
  int pc [3] = '{0, 3, 1};
  int m_sel [3];
  int m_rem [3];
  bit m_err [3];
  bit m_up  [3];
  bit last_acc [3];

  assign code_p1 = 2'(code[2]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pulsed_decoder_n #(.ENC_WIDTH(3), .NUM_OUTPUTS(6), .PULSE_CYCLES(0)) u_lvl (
    .Clock_In(clk), .Reset_In(rst), .Clear_In(clr[0]),
    .Encoded_Value_In(code[0]), .Encoded_Valid_In(vld[0]), .Encoded_Ready_Out(rdy[0]),
    .Decoded_Value_Out(val0), .Decoded_Valid_Out(dv[0]), .Error_Out(err[0]));

  pulsed_decoder_n #(.ENC_WIDTH(3), .NUM_OUTPUTS(5), .PULSE_CYCLES(3)) u_p3 (
    .Clock_In(clk), .Reset_In(rst), .Clear_In(clr[1]),
    .Encoded_Value_In(code[1]), .Encoded_Valid_In(vld[1]), .Encoded_Ready_Out(rdy[1]),
    .Decoded_Value_Out(val1), .Decoded_Valid_Out(dv[1]), .Error_Out(err[1]));

  pulsed_decoder_n #(.ENC_WIDTH(2), .NUM_OUTPUTS(4), .PULSE_CYCLES(1)) u_p1 (
    .Clock_In(clk), .Reset_In(rst), .Clear_In(clr[2]),
    .Encoded_Value_In(code_p1), .Encoded_Valid_In(vld[2]), .Encoded_Ready_Out(rdy[2]),
    .Decoded_Value_Out(val2), .Decoded_Valid_Out(dv[2]), .Error_Out(err[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs_val(input int i);
    case (i)
      0:       return 32'(val0);
      1:       return 32'(val1);
      default: return 32'(val2);
    endcase
  endfunction

  function automatic logic [31:0] exp_val(input int i);
    if (m_sel[i] < 0) return 32'd0;
    return 32'd1 << (np[i] - 1 - m_sel[i]);
  endfunction

  function automatic bit exp_rdy(input int i);
    return m_up[i] && !clr[i] && (pc[i] == 0 || m_sel[i] < 0);
  endfunction

  task automatic model_reset(input int i);
    m_sel[i] = -1;
    m_rem[i] = 0;
    m_err[i] = 1'b0;
    m_up[i]  = 1'b0;
  endtask

  task automatic model_step(input int i, input bit acc);
    if (clr[i]) begin
      m_sel[i] = -1;
      m_rem[i] = 0;
      m_err[i] = 1'b0;
    end else if (acc) begin
      if (int'(code[i]) < np[i]) begin
        m_sel[i] = int'(code[i]);
        m_rem[i] = pc[i];
      end else begin
        m_sel[i] = -1;
        m_err[i] = 1'b1;
      end
    end else if (pc[i] > 0 && m_sel[i] >= 0) begin
      m_rem[i]--;
      if (m_rem[i] == 0) m_sel[i] = -1;
    end
    m_up[i] = 1'b1;
  endtask

  // Called just after a falling edge with inputs already driven
  task automatic run_cycle();
    #2;
    for (int i = 0; i < 3; i++) begin
      if (rst) model_reset(i);
      check($sformatf("value[%0d]", i), obs_val(i), exp_val(i));
      check($sformatf("dvalid[%0d]", i), 32'(dv[i]), 32'(m_sel[i] >= 0));
      check($sformatf("error[%0d]", i), 32'(err[i]), 32'(m_err[i]));
      check($sformatf("ready[%0d]", i), 32'(rdy[i]), 32'(exp_rdy(i)));
      check($sformatf("onehot[%0d]", i), 32'($onehot0(obs_val(i))), 32'd1);
      last_acc[i] = vld[i] && exp_rdy(i);
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) model_reset(i);
      else     model_step(i, last_acc[i]);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    clr = '0;
    vld = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      code[i] = '0;
      model_reset(i);
      last_acc[i] = 1'b0;
    end
    @(negedge clk);
    run_cycle();
    run_cycle();
    rst = 1'b0;
    run_cycle();

    // Level mode: consecutive codes replace each other with no gap
    for (int k = 0; k < 4; k++) begin
      vld[0] = 1'b1; code[0] = 3'(k);
      run_cycle();
    end
    // Out-of-range while holding, then a valid code, then clear
    code[0] = 3'd2; run_cycle();
    code[0] = 3'd6; run_cycle();
    code[0] = 3'd5; run_cycle();
    vld[0] = 1'b0; clr[0] = 1'b1; run_cycle();
    clr[0] = 1'b0; run_cycle();

    // Pulse mode: code 1 then code 3 held valid until accepted
    vld[1] = 1'b1; code[1] = 3'd1; run_cycle();
    code[1] = 3'd3;
    for (int c = 0; c < 4; c++) run_cycle();
    vld[1] = 1'b0;
    for (int c = 0; c < 4; c++) run_cycle();

    // One-cycle pulses back to back: 0 then 2, each held until accepted
    vld[2] = 1'b1; code[2] = 3'd0; run_cycle();
    code[2] = 3'd2; run_cycle(); run_cycle();
    vld[2] = 1'b0; run_cycle(); run_cycle();

    // Clear coincident with a valid code, then the code re-presented
    clr = 3'b111; vld = 3'b111;
    for (int i = 0; i < 3; i++) code[i] = '0;
    run_cycle();
    clr = '0; run_cycle();
    idle_inputs(); run_cycle(); run_cycle(); run_cycle();

    // Asynchronous reset mid-pulse with two cycles remaining
    vld[1] = 1'b1; code[1] = 3'd1; run_cycle();
    vld[1] = 1'b0; run_cycle();
    rst = 1'b1; run_cycle();
    rst = 1'b0; run_cycle(); run_cycle(); run_cycle();

    // Random traffic; upstream holds a code until it is accepted
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!(vld[i] && !last_acc[i] && !clr[i])) begin
          vld[i]  = ($urandom_range(0, 2) != 0);
          code[i] = 3'($urandom_range(0, (i == 2) ? 3 : 7));
        end
        clr[i] = ($urandom_range(0, 24) == 0);
      end
      rst = ($urandom_range(0, 199) == 0);
      run_cycle();
    end
    rst = 1'b0;
    idle_inputs();
    run_cycle(); run_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
